botones_ar_param: RTL and testbench

Parametrised N-channel button conditioner, successor to the fixed 4-button debouncer bank.
- Synchronises each raw push-button input, debounces it, and outputs:
  - the clean level;
  - a one-cycle press pulse;
  - a one-cycle long-press pulse;
  - a toggle latch.
- Everything runs in the `clk` domain. No derived clocks, no edge-triggered logic on debounced signals.
- Sits between board pins and the mode/FSM logic (test, energy, medicine, reset-request buttons).

---
 rtl/botones_ar_pkg.sv | 19 +
 rtl/boton_ar_canal.sv | 141 ++++++++++++++
 rtl/botones_ar_param.sv | 36 +++
 tb/tb_botones_ar_param.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/botones_ar_pkg.sv
// Shared types and helpers for the parametrised button conditioner.
// Holds the per-channel FSM encoding and the counter width helper.
package botones_ar_pkg;

    typedef enum logic [1:0] {
        REPOSO           = 2'd0,
        CONFIRMA_PRESION = 2'd1,
        PRESIONADO       = 2'd2,
        CONFIRMA_SUELTA  = 2'd3
    } estado_boton_e;

    // Bits needed to hold 0..valor, never narrower than one bit.
    function automatic int ancho_contador(input int valor);
        int w;
        w = $clog2(valor + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/boton_ar_canal.sv
// One button channel: two-flop synchroniser, debounce FSM, long-press counter
// and optional toggle latch. Every output comes straight from a flop.
module boton_ar_canal
    import botones_ar_pkg::*;
#(
    parameter int CICLOS_ESTABLE  = 5,
    parameter int CICLOS_LARGO    = 20,
    parameter bit HABILITA_TOGGLE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic boton_in,
    output logic estado,
    output logic pulso,
    output logic pulso_largo,
    output logic senal_toggle
);

    localparam int CNT_W   = ancho_contador(CICLOS_ESTABLE);
    localparam int LARGO_W = ancho_contador(CICLOS_LARGO);

    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(CICLOS_ESTABLE);
    localparam logic [CNT_W-1:0]   CNT_UNO   = CNT_W'(1);
    localparam logic [LARGO_W-1:0] LARGO_MAX = LARGO_W'(CICLOS_LARGO);
    localparam logic [LARGO_W-1:0] LARGO_UNO = LARGO_W'(1);

    logic [1:0]         sync_q, sync_d;
    estado_boton_e      fsm_q, fsm_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LARGO_W-1:0] largo_q, largo_d;
    logic               estado_q, estado_d;
    logic               pulso_q, pulso_d;
    logic               pulso_largo_q, pulso_largo_d;
    logic               toggle_q, toggle_d;
    logic               s;

    assign s = sync_q[1];

    always_comb begin
        sync_d = {sync_q[0], boton_in};
    end

    always_comb begin
        fsm_d         = fsm_q;
        cnt_d         = cnt_q;
        largo_d       = largo_q;
        toggle_d      = toggle_q;
        pulso_d       = 1'b0;
        pulso_largo_d = 1'b0;

        case (fsm_q)
            REPOSO: begin
                largo_d = '0;
                if (s) begin
                    fsm_d = CONFIRMA_PRESION;
                    cnt_d = CNT_UNO;
                end
            end

            CONFIRMA_PRESION: begin
                if (!s) begin
                    fsm_d = REPOSO;
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    fsm_d   = PRESIONADO;
                    cnt_d   = '0;
                    largo_d = '0;
                    pulso_d = 1'b1;
                    if (HABILITA_TOGGLE) begin
                        toggle_d = ~toggle_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_UNO;
                end
            end

            PRESIONADO: begin
                // Saturating count gives exactly one long pulse per press.
                if (largo_q != LARGO_MAX) begin
                    largo_d = largo_q + LARGO_UNO;
                    if (largo_d == LARGO_MAX) begin
                        pulso_largo_d = 1'b1;
                    end
                end
                if (!s) begin
                    fsm_d = CONFIRMA_SUELTA;
                    cnt_d = CNT_UNO;
                end
            end

            CONFIRMA_SUELTA: begin
                if (s) begin
                    fsm_d = PRESIONADO;
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    fsm_d   = REPOSO;
                    cnt_d   = '0;
                    largo_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_UNO;
                end
            end

            default: begin
                fsm_d   = REPOSO;
                cnt_d   = '0;
                largo_d = '0;
            end
        endcase

        estado_d = (fsm_d == PRESIONADO) || (fsm_d == CONFIRMA_SUELTA);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q        <= '0;
            fsm_q         <= REPOSO;
            cnt_q         <= '0;
            largo_q       <= '0;
            estado_q      <= 1'b0;
            pulso_q       <= 1'b0;
            pulso_largo_q <= 1'b0;
            toggle_q      <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            fsm_q         <= fsm_d;
            cnt_q         <= cnt_d;
            largo_q       <= largo_d;
            estado_q      <= estado_d;
            pulso_q       <= pulso_d;
            pulso_largo_q <= pulso_largo_d;
            toggle_q      <= toggle_d;
        end
    end

    assign estado       = estado_q;
    assign pulso        = pulso_q;
    assign pulso_largo  = pulso_largo_q;
    assign senal_toggle = toggle_q;

endmodule

// File: rtl/botones_ar_param.sv
// N-channel button conditioner: one independent boton_ar_canal per input,
// with no priority or interaction between channels.
module botones_ar_param
    import botones_ar_pkg::*;
#(
    parameter int                   N_BOTONES      = 4,
    parameter int                   CICLOS_ESTABLE = 5,
    parameter int                   CICLOS_LARGO   = 20,
    parameter logic [N_BOTONES-1:0] MASCARA_TOGGLE = {N_BOTONES{1'b1}}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BOTONES-1:0] botones_in,
    output logic [N_BOTONES-1:0] estado,
    output logic [N_BOTONES-1:0] pulso,
    output logic [N_BOTONES-1:0] pulso_largo,
    output logic [N_BOTONES-1:0] senal_toggle
);

    for (genvar i = 0; i < N_BOTONES; i++) begin : g_canal
        boton_ar_canal #(
            .CICLOS_ESTABLE  (CICLOS_ESTABLE),
            .CICLOS_LARGO    (CICLOS_LARGO),
            .HABILITA_TOGGLE (MASCARA_TOGGLE[i])
        ) u_canal (
            .clk          (clk),
            .reset        (reset),
            .boton_in     (botones_in[i]),
            .estado       (estado[i]),
            .pulso        (pulso[i]),
            .pulso_largo  (pulso_largo[i]),
            .senal_toggle (senal_toggle[i])
        );
    end

endmodule

// File: tb/tb_botones_ar_param.sv
// Self-checking bench for botones_ar_param: directed scenarios plus random
// traffic, all compared against a run-length reference model of each channel.
module tb_botones_ar_param;

    localparam int         N    = 4;
    localparam int         CE   = 5;
    localparam int         CL   = 20;
    localparam logic [3:0] MASK = 4'b0111;

    logic       clk;
    logic       reset;
    logic [3:0] botones_in;
    logic [3:0] estado;
    logic [3:0] pulso;
    logic [3:0] pulso_largo;
    logic [3:0] senal_toggle;

    botones_ar_param #(
        .N_BOTONES      (N),
        .CICLOS_ESTABLE (CE),
        .CICLOS_LARGO   (CL),
        .MASCARA_TOGGLE (MASK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .botones_in   (botones_in),
        .estado       (estado),
        .pulso        (pulso),
        .pulso_largo  (pulso_largo),
        .senal_toggle (senal_toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: inputs delayed two edges, level flips after CE+1 consecutive
    // opposite samples, long count runs while pressed and not confirming release.
    logic [3:0] m_p1, m_p2, m_lvl, m_pulso, m_largo, m_tog;
    int         m_run [4];
    int         m_lng [4];

    logic [15:0] outs;
    assign outs = {estado, pulso, pulso_largo, senal_toggle};

    function automatic logic [15:0] model_out();
        return {m_lvl, m_pulso, m_largo, m_tog};
    endfunction

    task automatic model_edge(input logic [3:0] b, input logic r);
        logic [3:0] s;
        if (r) begin
            m_p1 = '0; m_p2 = '0; m_lvl = '0;
            m_pulso = '0; m_largo = '0; m_tog = '0;
            for (int c = 0; c < N; c++) begin
                m_run[c] = 0;
                m_lng[c] = 0;
            end
        end else begin
            s = m_p2;
            m_p2 = m_p1;
            m_p1 = b;
            m_pulso = '0;
            m_largo = '0;
            for (int c = 0; c < N; c++) begin
                if (m_lvl[c] && m_run[c] == 0 && m_lng[c] < CL) begin
                    m_lng[c]++;
                    if (m_lng[c] == CL) m_largo[c] = 1'b1;
                end
                if (s[c] != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == CE + 1) begin
                        m_lvl[c] = s[c];
                        m_run[c] = 0;
                        m_lng[c] = 0;
                        if (s[c]) begin
                            m_pulso[c] = 1'b1;
                            if (MASK[c]) m_tog[c] = ~m_tog[c];
                        end
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
        end
    endtask

    task automatic tick(input logic [3:0] b, input logic r);
        botones_in = b;
        reset      = r;
        @(posedge clk);
        model_edge(b, r);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(4'b1111, 1'b1);
            n_cmp++;
            if (outs !== 16'h0000) begin
                n_err++;
                $display("[TB] FAIL reset_hold: got %h expected 0000", outs);
            end
        end
        for (int i = 1; i <= 9; i++) begin
            tick(4'b1111, 1'b0);
            n_cmp++;
            if (outs !== model_out()) begin
                n_err++;
                $display("[TB] FAIL reset_release_model t=%0d: got %h expected %h", i, outs, model_out());
            end
            if (i == 7) begin
                n_cmp++;
                if (estado !== 4'b0000) begin
                    n_err++;
                    $display("[TB] FAIL reset_latency_early: got %b expected 0000", estado);
                end
            end
            if (i == 8) begin
                n_cmp++;
                if ({estado, pulso, senal_toggle} !== {4'b1111, 4'b1111, MASK}) begin
                    n_err++;
                    $display("[TB] FAIL reset_first_press: got %b expected %b", {estado, pulso, senal_toggle}, {4'b1111, 4'b1111, MASK});
                end
            end
            if (i == 9) begin
                n_cmp++;
                if (pulso !== 4'b0000) begin
                    n_err++;
                    $display("[TB] FAIL reset_pulse_width: got %b expected 0000", pulso);
                end
            end
        end
    endtask

    task automatic test_bounce();
        logic b0;
        logic tog0;
        int   npulse;
        for (int i = 0; i < 15; i++) begin
            tick(4'b0000, 1'b0);
            n_cmp++;
            if (outs !== model_out()) begin
                n_err++;
                $display("[TB] FAIL bounce_idle t=%0d: got %h expected %h", i, outs, model_out());
            end
        end
        tog0   = m_tog[0];
        npulse = 0;
        for (int j = 0; j < 32; j++) begin
            b0 = (j < 3) || (j >= 6 && j < 9) || (j >= 12 && j < 22);
            tick({3'b000, b0}, 1'b0);
            n_cmp++;
            if (outs !== model_out()) begin
                n_err++;
                $display("[TB] FAIL bounce_model t=%0d: got %h expected %h", j, outs, model_out());
            end
            if (pulso[0] === 1'b1) npulse++;
            if (j == 19) begin
                n_cmp++;
                if (pulso[0] !== 1'b1) begin
                    n_err++;
                    $display("[TB] FAIL bounce_pulse_time: got %b expected 1", pulso[0]);
                end
            end
        end
        n_cmp++;
        if (npulse != 1) begin
            n_err++;
            $display("[TB] FAIL bounce_pulse_count: got %0d expected 1", npulse);
        end
        n_cmp++;
        if (senal_toggle[0] !== ~tog0) begin
            n_err++;
            $display("[TB] FAIL bounce_toggle: got %b expected %b", senal_toggle[0], ~tog0);
        end
    endtask

    task automatic test_long_press();
        int nlong;
        nlong = 0;
        for (int j = 0; j < 45; j++) begin
            tick((j < 30) ? 4'b0010 : 4'b0000, 1'b0);
            n_cmp++;
            if (outs !== model_out()) begin
                n_err++;
                $display("[TB] FAIL long_model t=%0d: got %h expected %h", j, outs, model_out());
            end
            if (pulso_largo[1] === 1'b1) nlong++;
            if (j == 7) begin
                n_cmp++;
                if (pulso[1] !== 1'b1) begin
                    n_err++;
                    $display("[TB] FAIL long_press_pulse: got %b expected 1", pulso[1]);
                end
            end
            if (j == 27) begin
                n_cmp++;
                if (pulso_largo[1] !== 1'b1) begin
                    n_err++;
                    $display("[TB] FAIL long_pulse_time: got %b expected 1", pulso_largo[1]);
                end
            end
            if (j == 36 || j == 37) begin
                n_cmp++;
                if (estado[1] !== (j == 36)) begin
                    n_err++;
                    $display("[TB] FAIL long_release t=%0d: got %b expected %b", j, estado[1], (j == 36));
                end
            end
        end
        n_cmp++;
        if (nlong != 1) begin
            n_err++;
            $display("[TB] FAIL long_pulse_count: got %0d expected 1", nlong);
        end
    endtask

    task automatic test_short_press(input int ch, input string name);
        logic [3:0] b;
        logic       tog_start;
        int         npulse;
        int         nlong;
        tog_start = m_tog[ch];
        npulse    = 0;
        nlong     = 0;
        for (int j = 0; j < 48; j++) begin
            b = '0;
            b[ch] = ((j % 24) < 12);
            tick(b, 1'b0);
            n_cmp++;
            if (outs !== model_out()) begin
                n_err++;
                $display("[TB] FAIL %s_model t=%0d: got %h expected %h", name, j, outs, model_out());
            end
            if (pulso[ch] === 1'b1) npulse++;
            if (pulso_largo[ch] === 1'b1) nlong++;
            if (j == 8) begin
                n_cmp++;
                if (senal_toggle[ch] !== (MASK[ch] ? ~tog_start : 1'b0)) begin
                    n_err++;
                    $display("[TB] FAIL %s_toggle_first: got %b expected %b", name, senal_toggle[ch], (MASK[ch] ? ~tog_start : 1'b0));
                end
            end
        end
        n_cmp++;
        if (npulse != 2 || nlong != 0) begin
            n_err++;
            $display("[TB] FAIL %s_counts: got pulses=%0d long=%0d expected pulses=2 long=0", name, npulse, nlong);
        end
        n_cmp++;
        if (senal_toggle[ch] !== (MASK[ch] ? tog_start : 1'b0)) begin
            n_err++;
            $display("[TB] FAIL %s_toggle_final: got %b expected %b", name, senal_toggle[ch], (MASK[ch] ? tog_start : 1'b0));
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] b;
        for (int j = 0; j < 23; j++) begin
            b = {2'b00, 1'b1, (j >= 18)};
            tick(b, 1'b0);
            n_cmp++;
            if (outs !== model_out()) begin
                n_err++;
                $display("[TB] FAIL reset_mid_model t=%0d: got %h expected %h", j, outs, model_out());
            end
        end
        tick(4'b0011, 1'b1);
        n_cmp++;
        if (outs !== 16'h0000) begin
            n_err++;
            $display("[TB] FAIL reset_mid_clear: got %h expected 0000", outs);
        end
        for (int k = 1; k <= 9; k++) begin
            tick(4'b0011, 1'b0);
            n_cmp++;
            if (outs !== model_out()) begin
                n_err++;
                $display("[TB] FAIL reset_mid_after t=%0d: got %h expected %h", k, outs, model_out());
            end
            if (k == 7 || k == 8) begin
                n_cmp++;
                if ({estado, pulso} !== ((k == 8) ? 8'b0011_0011 : 8'h00)) begin
                    n_err++;
                    $display("[TB] FAIL reset_mid_latency t=%0d: got %b expected %b", k, {estado, pulso}, ((k == 8) ? 8'b0011_0011 : 8'h00));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] lvl;
        logic       r;
        int         rem [4];
        lvl = '0;
        for (int c = 0; c < N; c++) rem[c] = 0;
        for (int t = 0; t < 800; t++) begin
            for (int c = 0; c < N; c++) begin
                if (rem[c] == 0) begin
                    lvl[c] = 1'($urandom_range(0, 1));
                    rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 40)) : int'($urandom_range(1, 8));
                end
                rem[c]--;
            end
            r = ($urandom_range(0, 199) == 0);
            tick(lvl, r);
            n_cmp++;
            if (outs !== model_out()) begin
                n_err++;
                $display("[TB] FAIL random_model t=%0d: got %h expected %h", t, outs, model_out());
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        botones_in = 4'b0000;
        m_p1 = '0; m_p2 = '0; m_lvl = '0;
        m_pulso = '0; m_largo = '0; m_tog = '0;
        for (int c = 0; c < N; c++) begin
            m_run[c] = 0;
            m_lng[c] = 0;
        end
        $display("[TB] start");
        test_reset();
        test_bounce();
        test_long_press();
        test_short_press(2, "short_press");
        test_short_press(3, "mask");
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
